// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between the execute
// stage (requester 0) and load/store address generation (requester 1).
`ifndef ALU_SRC_REG
`define ALU_SRC_REG 1'b0
`endif
`ifndef ALU_SRC_IMM
`define ALU_SRC_IMM 1'b1
`endif

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_cpu,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_inst,
    input  logic             req0_use_imm,
    input  logic [WIDTH-1:0] req0_src_a,
    input  logic [WIDTH-1:0] req0_src_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_inst,
    input  logic             req1_use_imm,
    input  logic [WIDTH-1:0] req1_src_a,
    input  logic [WIDTH-1:0] req1_src_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_inst,
    output logic             alu_src_sel,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   owner;
    logic   grant;
    logic   grant_vld;
    logic   accept;
    logic   rsp_take;

    // Ties go to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_take   = 1'b0;
        busy       = !reset && (state != IDLE);
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        accept     = 1'b1;
                        req0_ready = ~grant;
                        req1_ready = grant;
                        state_next = EXEC;
                    end
                end
                EXEC: state_next = RESP;
                RESP: begin
                    rsp0_valid = ~owner;
                    rsp1_valid = owner;
                    rsp_take   = owner ? rsp1_ready : rsp0_ready;
                    if (rsp_take)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ALU inputs stay registered from accept until the response handshake.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_inst    <= '0;
            alu_src_sel <= `ALU_SRC_REG;
            alu_src_a   <= '0;
            alu_src_b   <= '0;
            rsp_data    <= '0;
            ops_done    <= '0;
        end else begin
            if (accept) begin
                owner       <= grant;
                last_grant  <= grant;
                alu_inst    <= grant ? req1_inst  : req0_inst;
                alu_src_a   <= grant ? req1_src_a : req0_src_a;
                alu_src_b   <= grant ? req1_src_b : req0_src_b;
                alu_src_sel <= (grant ? req1_use_imm : req0_use_imm) ? `ALU_SRC_IMM : `ALU_SRC_REG;
            end
            if (state == EXEC)
                rsp_data <= alu_result;
            if (rsp_take)
                ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests, per-requester expected-result queues
// drained by an independent response monitor, plus a simple ALU model.
`ifndef ALU_SRC_REG
`define ALU_SRC_REG 1'b0
`endif
`ifndef ALU_SRC_IMM
`define ALU_SRC_IMM 1'b1
`endif

module tb_alu_arbiter;

    localparam int WIDTH = 32;
    // Narrow counter so the wrap-around is reachable in a handful of ops.
    localparam int CNT_W = 4;

    logic             clk_cpu = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req0_use_imm;
    logic [WIDTH-1:0] req0_inst, req0_src_a, req0_src_b;
    logic             req1_valid, req1_ready, req1_use_imm;
    logic [WIDTH-1:0] req1_inst, req1_src_a, req1_src_b;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp_data, alu_inst, alu_src_a, alu_src_b, alu_result;
    logic             alu_src_sel, busy;
    logic [CNT_W-1:0] ops_done;
    logic [WIDTH-1:0] imm_ext;

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] exp0_q[$];
    logic [WIDTH-1:0] exp1_q[$];
    int               grant_log[$];
    logic [CNT_W-1:0] exp_ops = '0;

    always #5 clk_cpu = ~clk_cpu;

    // ALU model: immediate is the sign-extended top 12 bits of the instruction.
    assign imm_ext    = {{20{alu_inst[31]}}, alu_inst[31:20]};
    assign alu_result = alu_src_a + ((alu_src_sel == `ALU_SRC_IMM) ? imm_ext : alu_src_b);

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_inst(req0_inst),
        .req0_use_imm(req0_use_imm), .req0_src_a(req0_src_a), .req0_src_b(req0_src_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_inst(req1_inst),
        .req1_use_imm(req1_use_imm), .req1_src_a(req1_src_a), .req1_src_b(req1_src_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .alu_inst(alu_inst), .alu_src_sel(alu_src_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_result(alu_result),
        .busy(busy), .ops_done(ops_done)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the owner's queue on every accepted response.
    always @(negedge clk_cpu) begin
        if (!reset) begin
            if (req0_ready || req1_ready)
                check("single_ready", WIDTH'(req0_ready & req1_ready), '0);
            if (req0_ready) grant_log.push_back(0);
            if (req1_ready) grant_log.push_back(1);
            if (rsp0_valid || rsp1_valid)
                check("single_rsp_valid", WIDTH'(rsp0_valid & rsp1_valid), '0);
            if (rsp0_valid && rsp0_ready) begin
                if (exp0_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp0_unexpected: got 0x%0h, expected no response", rsp_data);
                end else
                    check("rsp0_data", rsp_data, exp0_q.pop_front());
                exp_ops++;
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp1_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp1_unexpected: got 0x%0h, expected no response", rsp_data);
                end else
                    check("rsp1_data", rsp_data, exp1_q.pop_front());
                exp_ops++;
            end
        end
    end

    // Presents one op and returns #1 after the accepting edge (EXEC cycle).
    task automatic send(input int r, input bit push, input logic [WIDTH-1:0] inst, input logic imm,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
        bit ok = 0;
        @(posedge clk_cpu); #1;
        if (r == 0) begin
            if (push) exp0_q.push_back(exp);
            req0_inst = inst; req0_use_imm = imm; req0_src_a = a; req0_src_b = b; req0_valid = 1'b1;
        end else begin
            if (push) exp1_q.push_back(exp);
            req1_inst = inst; req1_use_imm = imm; req1_src_a = a; req1_src_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_cpu);
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: requester %0d never got ready, expected within 60 cycles", r);
        end
        @(posedge clk_cpu); #1;
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_cpu);
            if (!busy && exp0_q.size() == 0 && exp1_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle within 100 cycles",
                     busy, exp0_q.size() + exp1_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_inst = '0; req0_use_imm = 1'b0; req0_src_a = '0; req0_src_b = '0;
        req1_valid = 1'b0; req1_inst = '0; req1_use_imm = 1'b0; req1_src_a = '0; req1_src_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset values, with a request pending to show ready is held off.
        repeat (3) @(negedge clk_cpu);
        check("rst_req0_ready", WIDTH'(req0_ready), '0);
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_ops_done", WIDTH'(ops_done), '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_alu_src_a", alu_src_a, '0);
        check("rst_alu_src_sel", WIDTH'(alu_src_sel), WIDTH'(`ALU_SRC_REG));
        @(posedge clk_cpu); #1;
        req0_valid = 1'b0;
        reset = 1'b0;

        // Requester 0 register add: ready one cycle, response two cycles later.
        send(0, 1, 32'h0000_0033, 1'b0, 32'd5, 32'd7, 32'd12);
        check("t1_ready_drop", WIDTH'(req0_ready), '0);
        @(negedge clk_cpu);
        check("t1_exec_busy", WIDTH'(busy), 1);
        check("t1_exec_rsp0", WIDTH'(rsp0_valid), '0);
        @(negedge clk_cpu);
        check("t1_rsp0_valid", WIDTH'(rsp0_valid), 1);
        check("t1_rsp_data", rsp_data, 32'd12);
        check("t1_rsp1_valid", WIDTH'(rsp1_valid), '0);
        wait_idle();
        check("t1_ops_done", WIDTH'(ops_done), 1);

        // Requester 1 immediate add.
        send(1, 1, 32'h0200_0013, 1'b1, 32'h100, 32'hDEAD, 32'h120);
        @(negedge clk_cpu);
        check("t2_src_sel", WIDTH'(alu_src_sel), WIDTH'(`ALU_SRC_IMM));
        @(negedge clk_cpu);
        check("t2_rsp1_valid", WIDTH'(rsp1_valid), 1);
        check("t2_rsp_data", rsp_data, 32'h120);
        wait_idle();
        check("t2_ops_done", WIDTH'(ops_done), 2);

        // Both requesters continuously busy: strict alternation.
        grant_log.delete();
        fork
            begin
                send(0, 1, 32'h0, 1'b0, 32'd1, 32'd2, 32'd3);
                send(0, 1, 32'h0, 1'b0, 32'h1000, 32'h0234, 32'h1234);
            end
            begin
                send(1, 1, 32'h0050_0013, 1'b1, 32'd10, 32'd0, 32'd15);
                send(1, 1, 32'hFFF0_0013, 1'b1, 32'h10, 32'd0, 32'hF);
            end
        join
        wait_idle();
        check("t3_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        check("t3_ops_done", WIDTH'(ops_done), 6);

        // Stalled response: owner held, other requester locked out.
        rsp0_ready = 1'b0;
        send(0, 1, 32'h0, 1'b0, 32'd10, 32'd20, 32'd30);
        exp1_q.push_back(32'd3);
        req1_inst = '0; req1_use_imm = 1'b0; req1_src_a = 32'd1; req1_src_b = 32'd2; req1_valid = 1'b1;
        @(negedge clk_cpu);
        check("t4_exec_req1_ready", WIDTH'(req1_ready), '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_cpu);
            check("t4_rsp0_valid", WIDTH'(rsp0_valid), 1);
            check("t4_rsp_data", rsp_data, 32'd30);
            check("t4_req1_ready", WIDTH'(req1_ready), '0);
            if (i == 4) begin
                @(posedge clk_cpu); #1;
                rsp0_ready = 1'b1;
            end
        end
        @(negedge clk_cpu);
        check("t4_req1_granted", WIDTH'(req1_ready), 1);
        @(posedge clk_cpu); #1;
        req1_valid = 1'b0;
        wait_idle();
        check("t4_ops_done", WIDTH'(ops_done), 8);

        // Result wraps modulo 2^WIDTH, then the counter wraps.
        send(0, 1, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        wait_idle();
        check("t5_ops_done", WIDTH'(ops_done), 9);
        for (int k = 0; k < 16 && exp_ops != '1; k++) begin
            send(k % 2, 1, 32'h0, 1'b0, k, 32'd100, k + 100);
            wait_idle();
        end
        check("t5_ops_full", WIDTH'(ops_done), 15);
        send(1, 1, 32'h0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0);
        wait_idle();
        check("t5_ops_wrap", WIDTH'(ops_done), 0);

        // Reset during EXEC discards the op and restores round-robin priority.
        send(1, 1, 32'h0, 1'b0, 32'd1, 32'd1, 32'd2);
        wait_idle();
        send(0, 0, 32'h0, 1'b0, 32'd11, 32'd22, 32'd33);
        reset = 1'b1;
        @(negedge clk_cpu);
        check("t6_rst_busy", WIDTH'(busy), '0);
        @(posedge clk_cpu); #1;
        reset = 1'b0;
        exp_ops = '0;
        @(negedge clk_cpu);
        check("t6_busy", WIDTH'(busy), '0);
        check("t6_rsp0_valid", WIDTH'(rsp0_valid), '0);
        check("t6_rsp1_valid", WIDTH'(rsp1_valid), '0);
        check("t6_ops_done", WIDTH'(ops_done), '0);
        grant_log.delete();
        fork
            send(0, 1, 32'h0, 1'b0, 32'd3, 32'd4, 32'd7);
            send(1, 1, 32'h0, 1'b0, 32'd8, 32'd9, 32'd17);
        join
        wait_idle();
        check("t6_grant_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("t6_grant_first", grant_log[0], 0);
            check("t6_grant_second", grant_log[1], 1);
        end
        check("t6_ops_done_after", WIDTH'(ops_done), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters: requester 0 is execute-stage ops, requester 1 is load/store address generation.
- Round-robin arbitration, latched operands, registered result, per-requester valid/ready handshakes on request and response.
- Sits between the decode/execute control and the ALU instance; drives the ALU's instruction, source-select and operand inputs and samples its result.

Parameters:
- WIDTH, 32, operand/result/instruction width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk_cpu  in  1  CPU clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle (valid & ready)
- req0_inst  in  WIDTH  instruction word (carries immediate field)
- req0_use_imm  in  1  1 = src_a + immediate, 0 = src_a + src_b
- req0_src_a  in  WIDTH  operand A
- req0_src_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_inst, req1_use_imm, req1_src_a, req1_src_b: same as requester 0
- rsp0_valid  out  1  result ready for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid  out  1  result ready for requester 1
- rsp1_ready  in  1  requester 1 takes result
- rsp_data  out  WIDTH  result, shared, valid with rspN_valid
- alu_inst  out  WIDTH  to ALU instruction input
- alu_src_sel  out  1  to ALU source-select control bit (`ALU_SRC_IMM when use_imm, else `ALU_SRC_REG)
- alu_src_a  out  WIDTH  to ALU operand A
- alu_src_b  out  WIDTH  to ALU operand B
- alu_result  in  WIDTH  from ALU (combinational)
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  completed (response-accepted) operation count

Behaviour:
- Reset values: state IDLE; last_grant = 1 (requester 0 wins first tie); alu_inst/alu_src_a/alu_src_b/rsp_data = 0; alu_src_sel = `ALU_SRC_REG; owner = 0; ops_done = 0.
- Reset forces reqN_ready, rspN_valid and busy to 0 in the cycle it is asserted.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration (combinational):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant !last_grant.
  - Neither valid: no grant.
- IDLE ready: reqN_ready = 1 only for the granted requester, and only when its valid is high; never both.
- IDLE on accept: latch inst/use_imm/src_a/src_b into the alu_* output registers, set owner = grant and last_grant = grant, go EXEC.
- EXEC: ALU operands stable. rsp_data <= alu_result; go RESP. Both reqN_ready = 0.
- RESP:
  - rsp{owner}_valid = 1; the other rspN_valid = 0.
  - rsp_data and alu_* outputs held stable until the handshake.
  - On rsp{owner}_ready: ops_done += 1 (wraps modulo 2^CNT_W), go IDLE.
  - rspN_ready of the non-owner is ignored.
- Latency: accept in cycle N, rsp valid in cycle N+2. Max throughput one op per 3 cycles with rsp_ready held high.
- Arithmetic: ALU result is modulo 2^WIDTH; the block does not inspect or alter it.
- Requests arriving while busy: not accepted; requesters must hold valid and operands until ready.
- Requester dropping valid before ready: no effect, and last_grant is unchanged.
- Reset mid-EXEC or mid-RESP: operation discarded, no response issued, ops_done cleared, state IDLE next cycle.

Test Plan:
- Req0 only, use_imm=0, src_a=5, src_b=7, rsp0_ready=1 -> req0_ready high 1 cycle; rsp0_valid 2 cycles later with rsp_data=12; ops_done=1; rsp1_valid never high.
- Req1 only, use_imm=1, src_a=0x100, imm field=0x20 -> alu_src_sel=`ALU_SRC_IMM during EXEC; rsp1_valid with rsp_data=0x120.
- Both valid continuously after reset, 4 ops -> grant order 0,1,0,1; never both readies high; ops_done=4.
- Req0 op, rsp0_ready held low 5 cycles -> rsp0_valid and rsp_data stable for 6 cycles; req1_valid high meanwhile but req1_ready stays 0; req1 granted in the first IDLE cycle after the handshake.
- Overflow: src_a=0xFFFFFFFF, src_b=1 -> rsp_data=0. Preload ops_done=0xFFFF via 65535 ops (or force), then one more -> ops_done=0.
- Reset asserted in EXEC cycle -> next cycle busy=0, rspN_valid=0, ops_done=0; then a new req0 (3+4) completes with rsp_data=7 and is granted before a simultaneous req1.
